// File: rtl/fetch_pkg.sv
// Shared types and constants for the dual-issue instruction fetch stage.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 8;
    localparam int INST_W       = 32;

    localparam logic [INST_W-1:0] INST_ECALL = 32'h0000_0073;

    typedef struct packed {
        logic [INST_W-1:0]       inst;
        logic [FETCH_ADDR_W-1:0] pc;
    } fetch_entry_t;

    // Zero an entry that is not being presented so stale queue data never leaks out.
    function automatic fetch_entry_t mask_entry(input fetch_entry_t e, input logic vld);
        fetch_entry_t r;
        r = vld ? e : '0;
        return r;
    endfunction

endpackage

// File: rtl/fetch_accept_chk.sv
// Protocol checker: the decoder may not consume more slots than are presented.
module fetch_accept_chk (
    input logic       clk,
    input logic       reset,
    input logic [1:0] dec_accept,
    input logic [1:0] out_valid
);

    logic [1:0] valid_cnt_s;

    assign valid_cnt_s = {1'b0, out_valid[1]} + {1'b0, out_valid[0]};

    // Over-consumption is clamped in hardware but is still a decoder bug.
    assert property (@(posedge clk) disable iff (reset) dec_accept <= valid_cnt_s)
        else $error("dec_accept exceeds presented slots");

endmodule

// File: rtl/fetch_queue.sv
// In-order circular buffer: up to two writes and two reads per cycle, reports
// the free space that remains once this cycle's reads are taken out.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic [1:0]         deq_cnt,
    input  logic [1:0]         enq_cnt,
    input  fetch_entry_t       enq_entry0,
    input  fetch_entry_t       enq_entry1,
    output fetch_entry_t       head0,
    output fetch_entry_t       head1,
    output logic [1:0]         valid_cnt,
    output logic [CNT_W-1:0]   free_cnt
);

    fetch_entry_t      mem_r [DEPTH];
    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic [1:0]        deq_eff_s;

    // Visible slots, clamped consume count and post-dequeue free space.
    always_comb begin
        valid_cnt = (count_r >= CNT_W'(2)) ? 2'd2 : count_r[1:0];
        deq_eff_s = (deq_cnt > valid_cnt) ? valid_cnt : deq_cnt;
        free_cnt  = CNT_W'(DEPTH) - count_r + CNT_W'(deq_eff_s);
        head0     = mask_entry(mem_r[head_r], valid_cnt >= 2'd1);
        head1     = mask_entry(mem_r[head_r + PTR_W'(1)], valid_cnt == 2'd2);
    end

    // Pointer and occupancy update; a flush drops every entry at once.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            head_r  <= head_r + PTR_W'(deq_eff_s);
            tail_r  <= tail_r + PTR_W'(enq_cnt);
            count_r <= count_r - CNT_W'(deq_eff_s) + CNT_W'(enq_cnt);
        end
    end

    // Entry storage; contents need no reset because reads are masked by occupancy.
    always_ff @(posedge clk) begin
        if (!(reset || flush)) begin
            if (enq_cnt >= 2'd1) begin
                mem_r[tail_r] <= enq_entry0;
            end
            if (enq_cnt == 2'd2) begin
                mem_r[tail_r + PTR_W'(1)] <= enq_entry1;
            end
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Dual-issue fetch stage: PC, redirect and top-of-memory wrap around a fetch queue.
// Optional ECALL fetch halt is built when FETCH_ECALL_HALT_EN is defined.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                      QDEPTH   = 4,
    parameter logic [FETCH_ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic [FETCH_ADDR_W-1:0] inst_address,
    input  logic [INST_W-1:0]       instruction1,
    input  logic [INST_W-1:0]       instruction2,
    input  logic                    redirect_valid,
    input  logic [FETCH_ADDR_W-1:0] redirect_pc,
    output logic [1:0]              out_valid,
    output logic [INST_W-1:0]       out_inst0,
    output logic [INST_W-1:0]       out_inst1,
    output logic [FETCH_ADDR_W-1:0] out_pc0,
    output logic [FETCH_ADDR_W-1:0] out_pc1,
    input  logic [1:0]              dec_accept
`ifdef FETCH_ECALL_HALT_EN
    , output logic                  fetch_halted
`endif
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;
    localparam logic [FETCH_ADDR_W-1:0] LAST_WORD_PC = 8'hFC;

    logic [FETCH_ADDR_W-1:0] pc_r;
    logic [FETCH_ADDR_W-1:0] pc_next_s;
    logic                    at_top_s;
    logic [1:0]              fetch_n_s;
    logic                    ecall_hit_s;
    logic                    halt_s;
    logic [1:0]              enq_cnt_s;
    logic [CNT_W-1:0]        free_cnt_s;
    logic [1:0]              valid_cnt_s;
    fetch_entry_t            enq_entry0_s;
    fetch_entry_t            enq_entry1_s;
    fetch_entry_t            head0_s;
    fetch_entry_t            head1_s;

    assign at_top_s     = (pc_r == LAST_WORD_PC);
    assign inst_address = pc_r;
    assign enq_entry0_s = '{inst: instruction1, pc: pc_r};
    assign enq_entry1_s = '{inst: instruction2, pc: pc_r + 8'd4};

    // Fetch sizing and next PC; a pair is enqueued whole or not at all.
    always_comb begin
        fetch_n_s   = at_top_s ? 2'd1 : 2'd2;
        ecall_hit_s = 1'b0;
`ifdef FETCH_ECALL_HALT_EN
        if (instruction1 == INST_ECALL) begin
            fetch_n_s   = 2'd1;
            ecall_hit_s = 1'b1;
        end else if (!at_top_s && (instruction2 == INST_ECALL)) begin
            ecall_hit_s = 1'b1;
        end else begin
            ecall_hit_s = 1'b0;
        end
`endif
        if (!redirect_valid && !halt_s && (free_cnt_s >= CNT_W'(fetch_n_s))) begin
            enq_cnt_s = fetch_n_s;
        end else begin
            enq_cnt_s = 2'd0;
        end

        if (redirect_valid) begin
            pc_next_s = {redirect_pc[7:2], 2'b00};
        end else if ((enq_cnt_s != 2'd0) && !ecall_hit_s) begin
            pc_next_s = pc_r + {4'd0, fetch_n_s, 2'b00};
        end else begin
            pc_next_s = pc_r;
        end
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

`ifdef FETCH_ECALL_HALT_EN
    logic halt_r;

    // Halt sets once an ECALL is actually enqueued; redirect or reset releases it.
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            halt_r <= 1'b0;
        end else if ((enq_cnt_s != 2'd0) && ecall_hit_s) begin
            halt_r <= 1'b1;
        end else begin
            halt_r <= halt_r;
        end
    end

    assign halt_s       = halt_r;
    assign fetch_halted = halt_r;
`else
    assign halt_s = 1'b0;
`endif

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .deq_cnt    (dec_accept),
        .enq_cnt    (enq_cnt_s),
        .enq_entry0 (enq_entry0_s),
        .enq_entry1 (enq_entry1_s),
        .head0      (head0_s),
        .head1      (head1_s),
        .valid_cnt  (valid_cnt_s),
        .free_cnt   (free_cnt_s)
    );

    // Slot 1 is only ever valid together with slot 0.
    always_comb begin
        case (valid_cnt_s)
            2'd2:    out_valid = 2'b11;
            2'd1:    out_valid = 2'b01;
            default: out_valid = 2'b00;
        endcase
    end

    assign out_inst0 = head0_s.inst;
    assign out_pc0   = head0_s.pc;
    assign out_inst1 = head1_s.inst;
    assign out_pc1   = head1_s.pc;

    fetch_accept_chk u_chk (
        .clk        (clk),
        .reset      (reset),
        .dec_accept (dec_accept),
        .out_valid  (out_valid)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: a queue-based reference model predicts
// every cycle's outputs, a monitor compares them on the falling edge.
module tb_inst_fetch_unit;
    import fetch_pkg::*;

    localparam int QDEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  inst_address;
    logic [31:0] instruction1;
    logic [31:0] instruction2;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic [1:0]  out_valid;
    logic [31:0] out_inst0;
    logic [31:0] out_inst1;
    logic [7:0]  out_pc0;
    logic [7:0]  out_pc1;
    logic [1:0]  dec_accept;
`ifdef FETCH_ECALL_HALT_EN
    logic        fetch_halted;
`endif

    logic [31:0] mem [64];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign instruction1 = mem[inst_address[7:2]];
    assign instruction2 = mem[inst_address[7:2] + 6'd1];

    inst_fetch_unit #(.QDEPTH(QDEPTH), .RESET_PC(8'h00)) dut (
        .clk            (clk),
        .reset          (reset),
        .inst_address   (inst_address),
        .instruction1   (instruction1),
        .instruction2   (instruction2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_inst0      (out_inst0),
        .out_inst1      (out_inst1),
        .out_pc0        (out_pc0),
        .out_pc1        (out_pc1),
        .dec_accept     (dec_accept)
`ifdef FETCH_ECALL_HALT_EN
        , .fetch_halted (fetch_halted)
`endif
    );

    typedef struct packed {
        logic [1:0]  v;
        logic [31:0] i0;
        logic [7:0]  p0;
        logic [31:0] i1;
        logic [7:0]  p1;
        logic [7:0]  addr;
        logic        h;
    } exp_t;

    // Reference model state: architectural queue contents, PC and halt flag.
    fetch_entry_t mq[$];
    logic [7:0]   mpc;
    bit           mhalt;
    bit           mknown = 1'b0;
    exp_t         exp_q[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic int avail();
        return (mq.size() < 2) ? mq.size() : 2;
    endfunction

    function automatic void push_expected();
        exp_t e;
        e.v    = (mq.size() >= 2) ? 2'b11 : ((mq.size() == 1) ? 2'b01 : 2'b00);
        e.i0   = (mq.size() >= 1) ? mq[0].inst : 32'h0;
        e.p0   = (mq.size() >= 1) ? mq[0].pc   : 8'h00;
        e.i1   = (mq.size() >= 2) ? mq[1].inst : 32'h0;
        e.p1   = (mq.size() >= 2) ? mq[1].pc   : 8'h00;
        e.addr = mpc;
        e.h    = mhalt;
        exp_q.push_back(e);
    endfunction

    function automatic void model_step(input bit rst, input bit redir, input logic [7:0] rpc, input int acc);
        logic [31:0] w [2];
        int          ntake;
        bit          ec;
        if (rst) begin
            mq.delete();
            mpc    = 8'h00;
            mhalt  = 1'b0;
            mknown = 1'b1;
        end else if (redir) begin
            mq.delete();
            mpc   = rpc & 8'hFC;
            mhalt = 1'b0;
        end else begin
            for (int k = 0; k < acc; k++) void'(mq.pop_front());
            if (!mhalt) begin
                ntake = (mpc == 8'hFC) ? 1 : 2;
                w[0]  = mem[mpc[7:2]];
                w[1]  = mem[mpc[7:2] + 6'd1];
                ec    = 1'b0;
`ifdef FETCH_ECALL_HALT_EN
                for (int k = 0; k < ntake; k++) begin
                    if (w[k] == INST_ECALL) begin
                        ntake = k + 1;
                        ec    = 1'b1;
                        break;
                    end
                end
`endif
                if (QDEPTH - mq.size() >= ntake) begin
                    for (int k = 0; k < ntake; k++)
                        mq.push_back(fetch_entry_t'{inst: w[k], pc: mpc + 8'(4 * k)});
                    if (ec) mhalt = 1'b1;
                    else    mpc   = mpc + 8'(4 * ntake);
                end
            end
        end
    endfunction

    // One clock cycle: predict this cycle's outputs, drive inputs, advance the model.
    task automatic cycle(input bit rst, input bit redir, input logic [7:0] rpc, input int acc);
        if (mknown) push_expected();
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        dec_accept     = 2'(acc);
        @(posedge clk);
        model_step(rst, redir, rpc, acc);
        #2;
    endtask

    // Monitor: compares every predicted cycle against the DUT on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_valid",    32'(out_valid),    32'(e.v));
                chk("out_inst0",    out_inst0,         e.i0);
                chk("out_pc0",      32'(out_pc0),      32'(e.p0));
                chk("out_inst1",    out_inst1,         e.i1);
                chk("out_pc1",      32'(out_pc1),      32'(e.p1));
                chk("inst_address", 32'(inst_address), 32'(e.addr));
`ifdef FETCH_ECALL_HALT_EN
                chk("fetch_halted", 32'(fetch_halted), 32'(e.h));
`endif
            end
        end
    end

    initial begin
        int pat [4] = '{1, 2, 1, 0};
        int a;
        logic [31:0] r;

        for (int k = 0; k < 64; k++) begin
            do r = $urandom(); while (r == INST_ECALL);
            mem[k] = r;
        end
        mem[0]  = 32'h0050_0093;
        mem[1]  = 32'hff20_0113;
        mem[10] = 32'h0020_85b3;
        mem[11] = 32'h00b1_8633;

        cycle(1'b1, 1'b0, 8'h00, 0);
        cycle(1'b1, 1'b0, 8'h00, 0);

        // Reset-to-fetch
        cycle(1'b0, 1'b0, 8'h00, 0);
        chk("rst_fetch_valid", 32'(out_valid), 32'(2'b11));
        chk("rst_fetch_inst0", out_inst0, 32'h0050_0093);
        chk("rst_fetch_pc1",   32'(out_pc1), 32'h04);
        chk("rst_fetch_inst1", out_inst1, 32'hff20_0113);

        // Backpressure: six cycles without consumption, then drain two
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 8'h00, 0);
        chk("bp_pc_hold", 32'(inst_address), 32'h10);
        chk("bp_head",    32'(out_pc0), 32'h00);
        cycle(1'b0, 1'b0, 8'h00, 2);
        chk("bp_pc0_after", 32'(out_pc0), 32'h08);
        chk("bp_pc1_after", 32'(out_pc1), 32'h0C);
        chk("bp_refill",    32'(inst_address), 32'h18);

        // Redirect while full
        cycle(1'b0, 1'b1, 8'h2A, 0);
        chk("redir_empty", 32'(out_valid), 32'(2'b00));
        cycle(1'b0, 1'b0, 8'h00, 0);
        chk("redir_pc0",   32'(out_pc0), 32'h28);
        chk("redir_inst0", out_inst0, 32'h0020_85b3);
        chk("redir_pc1",   32'(out_pc1), 32'h2C);
        chk("redir_inst1", out_inst1, 32'h00b1_8633);

        // Top-of-memory wrap
        cycle(1'b0, 1'b1, 8'hFC, 0);
        cycle(1'b0, 1'b0, 8'h00, 0);
        chk("wrap_single", 32'(out_valid), 32'(2'b01));
        chk("wrap_pc0",    32'(out_pc0), 32'hFC);
        chk("wrap_pc",     32'(inst_address), 32'h00);
        cycle(1'b0, 1'b0, 8'h00, 0);
        chk("wrap_pc1", 32'(out_pc1), 32'h00);
        cycle(1'b0, 1'b0, 8'h00, 1);
        chk("wrap_next0", 32'(out_pc0), 32'h00);
        chk("wrap_next1", 32'(out_pc1), 32'h04);

        // Mixed consume pattern with continuous fetch
        for (int k = 0; k < 40; k++) begin
            a = pat[k % 4];
            if (a > avail()) a = avail();
            cycle(1'b0, 1'b0, 8'h00, a);
        end

        // Sustained full-rate consumption
        for (int k = 0; k < 20; k++) cycle(1'b0, 1'b0, 8'h00, avail());

        // Randomised traffic with occasional redirects and resets
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0)
                cycle(1'b1, 1'b0, 8'h00, 0);
            else if ($urandom_range(0, 19) == 0)
                cycle(1'b0, 1'b1, 8'($urandom()), avail());
            else
                cycle(1'b0, 1'b0, 8'h00, $urandom_range(0, avail()));
        end

`ifdef FETCH_ECALL_HALT_EN
        // ECALL halt and redirect release
        mem[4] = INST_ECALL;
        cycle(1'b0, 1'b1, 8'h00, 0);
        for (int k = 0; k < 12; k++) cycle(1'b0, 1'b0, 8'h00, avail());
        chk("halt_set",     32'(fetch_halted), 32'h1);
        chk("halt_pc_hold", 32'(inst_address), 32'h10);
        cycle(1'b0, 1'b1, 8'h00, 0);
        chk("halt_clear", 32'(fetch_halted), 32'h0);
        cycle(1'b0, 1'b0, 8'h00, 0);
        chk("halt_resume", 32'(inst_address), 32'h08);
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 8'h00, avail());
`endif

        reset          = 1'b0;
        redirect_valid = 1'b0;
        dec_accept     = 2'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Dual-issue instruction fetch stage. Owns the program counter and drives the byte address into the instruction memory, whose two 32-bit instruction outputs are combinational from that address. Captures each fetched pair into a small in-order queue and presents up to two instructions per cycle, each with its PC, to the dual-issue decoder. Handles branch/jump redirects by flushing the queue and reloading the PC.

## Interface
- `QDEPTH`, default 4: queue entries. Each entry holds one instruction and its PC. Must be a power of two and at least 4.
- `RESET_PC`, default 8'h00: PC value loaded on reset.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `inst_address` out 8: byte address to instruction memory. Always equals the PC register.
- `instruction1` in 32: memory word at `inst_address`.
- `instruction2` in 32: memory word at `inst_address+4`.
- `redirect_valid` in 1: branch/jump taken this cycle.
- `redirect_pc` in 8: redirect target. Bits [1:0] are ignored and forced to 0.
- `out_valid` out 2: `2'b00`, `2'b01` or `2'b11`. Slot 1 is never valid without slot 0.
- `out_inst0`, `out_inst1` out 32: queue head and head+1.
- `out_pc0`, `out_pc1` out 8: PCs of those slots.
- `dec_accept` in 2: count consumed this cycle (0..2). Must not exceed the number of valid slots.
- `fetch_halted` out 1: only present with the macro (see Configuration). Otherwise tie-free/absent.

## Operation
- Queue: circular buffer with head pointer, tail pointer and count (log2(QDEPTH)+1 bits). `out_*` are combinational from head and head+1, with pointers wrapping modulo QDEPTH.
- Per cycle, priority order:
  1. `reset`
  2. `redirect_valid`
  3. normal dequeue + enqueue
- Reset:
  - PC = RESET_PC; count, head and tail = 0.
  - `out_valid` = 0; `out_inst*` = 0 and `out_pc*` = 0 when invalid (outputs are masked).
  - `fetch_halted` = 0.
  - A reset asserted mid-operation discards all queue contents immediately.
- Redirect:
  - Queue is emptied.
  - PC = {redirect_pc[7:2], 2'b00}.
  - `dec_accept` and this cycle's fetch are ignored.
- Normal cycle:
  - Dequeue `dec_accept` entries.
  - Free space is computed after the dequeue.
  - If free space ≥ 2: enqueue (instruction1, PC) then (instruction2, PC+4); PC += 8.
  - If free space < 2: no enqueue; PC holds. Fetch is all-or-nothing per pair.
- Top-of-memory: if PC == 8'hFC, the memory's second word is out of range.
  - Enqueue instruction1 only; this needs free space ≥ 1.
  - PC wraps to 8'h00.
- Arithmetic: PC adds are 8-bit, modulo 256. A PC of 8'hF8 + 8 gives 8'h00.
- `dec_accept` above the valid count is a protocol error. Flag it with a simulation assertion; the RTL clamps it to the valid count.

## Timing
- `inst_address` is registered and changes only on a clock edge.
- Enqueue latency: a pair fetched in cycle N is visible on `out_*` in cycle N+1.
- After reset deasserts in cycle 0: PC 0 is fetched in cycle 0, and `out_valid` = 2'b11 in cycle 1.
- Redirect asserted in cycle N:
  - `out_valid` = 0 in N+1, while the target is fetched.
  - Target instructions are valid in N+2.
- Throughput: 2 instructions/cycle sustained when `dec_accept` = 2 every cycle. The queue never stalls in that case.
- Simultaneous full queue and `dec_accept` = 2: the freed space is used in the same cycle, with no bubble.

## Configuration
- Macro: `FETCH_ECALL_HALT_EN`.
- Defined:
  - An instruction equal to 32'h00000073 (ECALL) is enqueued normally.
  - In the same pair, a following instruction2 is dropped.
  - PC holds and `fetch_halted` = 1; no further enqueues.
  - A redirect or reset clears the halt.
- Undefined: ECALL is not special, and the `fetch_halted` port does not exist.

## Structure
- Shared package `fetch_pkg`:
  - `FETCH_ADDR_W` = 8
  - `INST_W` = 32
  - `INST_ECALL` = 32'h00000073
  - typedef `fetch_entry_t` {inst, pc}
- One sub-module, `fetch_queue`: a parameterised 2-in/2-out circular buffer reporting free count.
- `inst_fetch_unit` keeps the PC, redirect, wrap and halt logic.

## Test plan
- Reset-to-fetch. Memory holds 00500093 at 0 and ff200113 at 4; release reset → cycle 1: `out_valid` = 11, `out_inst0` = 00500093 with `out_pc0` = 0, `out_inst1` = ff200113 with `out_pc1` = 4.
- Backpressure. `dec_accept` = 0 for 6 cycles → the queue fills with PCs 0..12, PC holds at 16, and `out_pc0` stays 0. Then `dec_accept` = 2 → the next cycle shows PCs 8/12, and a refill from 16 follows.
- Redirect. Redirect to 8'h2A while the queue is full → next cycle `out_valid` = 0. The cycle after: `out_pc0` = 0x28, `out_inst0` = 002085b3; `out_pc1` = 0x2C, `out_inst1` = 00b18633.
- Wrap. Redirect to 8'hFC → exactly one entry enqueued (pc FC), then PC 0 is fetched; the following outputs show PCs FC, 0, 4 in order.
- Mixed consume. `dec_accept` pattern 1,2,1,0 with a continuous fetch → the PC stream seen at `out_pc0` is strictly +4 sequential, with no duplicates or drops.
- Macro on. ECALL placed at 0x10 → entries up to PC 0x10 are delivered, 0x14 is never enqueued, and `fetch_halted` = 1. Then redirect to 0 → `fetch_halted` = 0 and fetch resumes.
